// File: rtl/ov7670_capture_if.sv
// ov7670_capture_if: camera byte stream in, frame buffer write port and status out.
interface ov7670_capture_if #(parameter int ADDR_W = 17);
    logic              cap_en;
    logic              vsync;
    logic              href;
    logic [7:0]        data;
    logic              we;
    logic [ADDR_W-1:0] wAddr;
    logic [11:0]       wData;
    logic              frame_done;
    logic              busy;
    modport master (output cap_en, vsync, href, data, input we, wAddr, wData, frame_done, busy);
    modport slave  (input cap_en, vsync, href, data, output we, wAddr, wData, frame_done, busy);
endinterface

// File: rtl/ov7670_capture.sv
// ov7670_capture: packs OV7670 RGB565 byte pairs into RGB444 pixels written at y*H_PIX+x.
module ov7670_capture #(
    parameter int H_PIX   = 320,
    parameter int V_LINES = 240,
    parameter int ADDR_W  = 17
) (
    input logic clk,
    input logic reset_n,
    ov7670_capture_if.slave cam
);
    localparam int XW = $clog2(H_PIX + 1);
    localparam int YW = $clog2(V_LINES + 1);

    typedef enum logic [1:0] {S_SYNC, S_VBLK, S_CAPT, S_SKIP} state_t;
    state_t state, state_nx;

    logic          r_vsync, r_href, p_vsync, p_href;
    logic [7:0]    r_data, hi;
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic          phase, line_pix, wrote;
    logic          v_rise, v_fall, h_fall, take, pix, fit;
    logic [ADDR_W-1:0] addr;

    assign v_rise   = r_vsync & ~p_vsync;
    assign v_fall   = ~r_vsync & p_vsync;
    assign h_fall   = p_href & ~r_href;
    assign take     = (state == S_CAPT) && r_href && !r_vsync;
    assign pix      = take && phase;
    assign fit      = (x < XW'(H_PIX)) && (y < YW'(V_LINES));
    assign addr     = ADDR_W'(y) * ADDR_W'(H_PIX) + ADDR_W'(x);
    assign cam.busy = (state == S_CAPT);

    // every state except vertical blanking leaves on a vsync rise
    always_comb begin
        state_nx = state;
        if (state == S_VBLK)
            state_nx = v_fall ? (cam.cap_en ? S_CAPT : S_SKIP) : S_VBLK;
        else if (v_rise)
            state_nx = S_VBLK;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= S_SYNC;
            r_vsync        <= 1'b0;
            r_href         <= 1'b0;
            r_data         <= '0;
            p_vsync        <= 1'b0;
            p_href         <= 1'b0;
            hi             <= '0;
            x              <= '0;
            y              <= '0;
            phase          <= 1'b0;
            line_pix       <= 1'b0;
            wrote          <= 1'b0;
            cam.we         <= 1'b0;
            cam.wAddr      <= '0;
            cam.wData      <= '0;
            cam.frame_done <= 1'b0;
        end else begin
            state          <= state_nx;
            r_vsync        <= cam.vsync;
            r_href         <= cam.href;
            r_data         <= cam.data;
            p_vsync        <= r_vsync;
            p_href         <= r_href;
            cam.we         <= pix && fit;
            cam.frame_done <= (state == S_CAPT) && v_rise && wrote;
            if (pix && fit) begin
                cam.wAddr <= addr;
                cam.wData <= {hi[7:4], hi[2:0], r_data[7], r_data[4:1]};
                wrote     <= 1'b1;
            end
            if (state == S_VBLK && v_fall) begin
                x        <= '0;
                y        <= '0;
                phase    <= 1'b0;
                line_pix <= 1'b0;
                wrote    <= 1'b0;
            end else if (take) begin
                phase <= ~phase;
                if (!phase)
                    hi <= r_data;
                else begin
                    line_pix <= 1'b1;
                    if (x < XW'(H_PIX)) x <= x + 1'b1;
                end
            end else if (state == S_CAPT && h_fall) begin
                // a dangling high byte is dropped; empty lines do not advance y
                x        <= '0;
                phase    <= 1'b0;
                line_pix <= 1'b0;
                if (line_pix && y < YW'(V_LINES)) y <= y + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_ov7670_capture.sv
// tb_ov7670_capture: drives directed camera frames on a reduced raster and checks writes against a pixel model.
module tb_ov7670_capture;
    localparam int H  = 20;
    localparam int V  = 12;
    localparam int AW = 17;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    ov7670_capture_if #(.ADDR_W(AW)) cam();
    ov7670_capture #(.H_PIX(H), .V_LINES(V), .ADDR_W(AW)) dut (
        .clk(clk), .reset_n(reset_n), .cam(cam.slave));

    int n_chk = 0, n_fail = 0, nw = 0, fd_cnt = 0, np = 0;
    bit cap_frame = 1'b0;
    logic [AW+11:0] exp_q[$];
    int log_a[$];
    int log_d[$];
    logic [7:0] fixed[$];

    task automatic chk(string name, int act, int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    function automatic logic [11:0] rgb(logic [15:0] word);
        int w = int'(word);
        int r = w / 2048, g = (w / 32) % 64, b = w % 32;
        return 12'((r / 2) * 256 + (g / 4) * 16 + b / 2);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (reset_n) begin
            if (cam.we === 1'b1) begin
                logic [AW+11:0] e;
                nw++;
                log_a.push_back(int'(cam.wAddr));
                log_d.push_back(int'(cam.wData));
                chk("addr_range", int'(int'(cam.wAddr) <= H*V-1), 1);
                if (exp_q.size() == 0)
                    chk("unexpected_write", int'(cam.wAddr), -1);
                else begin
                    e = exp_q.pop_front();
                    chk("waddr", int'(cam.wAddr), int'(e[AW+11:12]));
                    chk("wdata", int'(cam.wData), int'(e[11:0]));
                end
            end
            if (cam.frame_done === 1'b1) fd_cnt++;
        end
    end

    task automatic vblank(bit cap);
        int fd0 = fd_cnt;
        int exp_done = (cap_frame && np > 0) ? 1 : 0;
        cam.vsync = 1'b1;
        cam.href  = 1'b0;
        repeat (6) tick();
        chk("frame_done", fd_cnt - fd0, exp_done);
        chk("pending", exp_q.size(), 0);
        cam.cap_en = cap;
        cap_frame  = cap;
        np = 0;
        cam.vsync = 1'b0;
        repeat (3) tick();
        chk("busy", int'(cam.busy), int'(cap));
    endtask

    task automatic body(int lines, int nb, int seed, int cap_line, int rel_byte);
        int y = 0;
        logic [7:0] hi = '0, d;
        for (int l = 0; l < lines; l++) begin
            if (l == cap_line) cam.cap_en = 1'b1;
            cam.href = 1'b1;
            for (int b = 0; b < nb; b++) begin
                if (l == 0 && b == rel_byte) reset_n = 1'b1;
                if (fixed.size() > 0) d = fixed.pop_front();
                else d = 8'((b * 37 + l * 11 + seed * 5) % 256);
                cam.data = d;
                if (b % 2 == 1 && cap_frame && b / 2 < H && y < V) begin
                    exp_q.push_back({AW'(y * H + b / 2), rgb({hi, d})});
                    np++;
                end
                hi = d;
                tick();
            end
            cam.href = 1'b0;
            cam.data = '0;
            if (nb >= 2) y++;
            repeat (3) tick();
        end
    endtask

    initial begin
        int nw0, fd0;
        cam.cap_en = 1'b0;
        cam.vsync  = 1'b0;
        cam.href   = 1'b0;
        cam.data   = '0;
        repeat (3) tick();
        chk("rst_we", int'(cam.we), 0);
        chk("rst_waddr", int'(cam.wAddr), 0);
        chk("rst_wdata", int'(cam.wData), 0);
        chk("rst_frame_done", int'(cam.frame_done), 0);
        chk("rst_busy", int'(cam.busy), 0);
        reset_n = 1'b1;
        tick();

        // full frame
        vblank(1);
        log_a.delete(); nw0 = nw;
        body(V, 2*H, 1, -1, -1);
        fd0 = fd_cnt;
        vblank(1);
        chk("t1_writes", nw - nw0, H*V);
        chk("t1_last_addr", log_a.size() > 0 ? log_a[log_a.size()-1] : -1, H*V-1);
        chk("t1_frame_done", fd_cnt - fd0, 1);

        // colour packing
        fixed = '{8'hF8, 8'h1F, 8'h07, 8'hE0};
        log_a.delete(); log_d.delete();
        body(1, 4, 0, -1, -1);
        chk("t2_addr0", log_a.size() > 0 ? log_a[0] : -1, 0);
        chk("t2_data0", log_d.size() > 0 ? log_d[0] : -1, 12'hF0F);
        chk("t2_addr1", log_a.size() > 1 ? log_a[1] : -1, 1);
        chk("t2_data1", log_d.size() > 1 ? log_d[1] : -1, 12'h0F0);
        vblank(1);

        // reset mid-frame, released while the frame keeps running
        body(3, 2*H, 3, -1, -1);
        reset_n = 1'b0;
        #1;
        chk("t3_rst_we", int'(cam.we), 0);
        chk("t3_rst_waddr", int'(cam.wAddr), 0);
        chk("t3_rst_wdata", int'(cam.wData), 0);
        chk("t3_rst_busy", int'(cam.busy), 0);
        cap_frame = 1'b0; np = 0; exp_q.delete();
        repeat (2) tick();
        log_a.delete();
        body(3, 2*H, 4, -1, 5);
        chk("t3_no_writes", log_a.size(), 0);
        vblank(1);
        log_a.delete();
        body(2, 4, 5, -1, -1);
        chk("t3_first_addr", log_a.size() > 0 ? log_a[0] : -1, 0);

        // overrun in both directions
        vblank(1);
        nw0 = nw;
        body(V + 10, 2*(H + 10), 7, -1, -1);
        fd0 = fd_cnt;
        vblank(0);
        chk("t4_writes", nw - nw0, H*V);
        chk("t4_frame_done", fd_cnt - fd0, 1);

        // cap_en raised mid-frame has no effect until next frame
        nw0 = nw;
        body(3, 2*H, 8, 1, -1);
        fd0 = fd_cnt;
        vblank(1);
        chk("t5_writes", nw - nw0, 0);
        chk("t5_frame_done", fd_cnt - fd0, 0);
        nw0 = nw;
        body(2, 2*H, 9, -1, -1);
        vblank(1);
        chk("t5_next_writes", nw - nw0, 2*H);

        // odd byte count per line
        log_a.delete(); nw0 = nw;
        body(2, 2*H + 1, 10, -1, -1);
        vblank(1);
        chk("t6_writes", nw - nw0, 2*H);
        chk("t6_line2_addr", log_a.size() > H ? log_a[H] : -1, H);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
